// File: rtl/vga_debug_display_if.sv
// Debug-probe bundle between the pipeline core and the VGA debug display.
// The core side drives the DBG_* probes; the display side drives the 7-bit VGA connector.
interface vga_debug_display_if;
   logic [7:0]  DBG_PC;
   logic [15:0] DBG_INSN;
   logic [15:0] DBG_WD;
   logic        DBG_WE;
   logic [6:0]  VGA;

   modport master (
      output DBG_PC,
      output DBG_INSN,
      output DBG_WD,
      output DBG_WE,
      input  VGA
   );

   modport slave (
      input  DBG_PC,
      input  DBG_INSN,
      input  DBG_WD,
      input  DBG_WE,
      output VGA
   );
endinterface

// File: rtl/vga_debug_display.sv
// 640x480@60 raster that paints PC / IF-ID instruction / writeback data as 16-cell bit bars.
// Probes are snapshotted once per frame at the start of vertical blank, so the picture never tears.
module vga_debug_display (
   input  logic               CLK,
   input  logic               RST_N,
   vga_debug_display_if.slave dbg
);

   logic [1:0]  div_q,       div_d;
   logic [9:0]  h_q,         h_d;
   logic [9:0]  v_q,         v_d;
   logic [3:0]  c_q,         c_d;
   logic [5:0]  o_q,         o_d;
   logic [15:0] wd_live_q,   wd_live_d;
   logic [15:0] snap_insn_q, snap_insn_d;
   logic [15:0] snap_wd_q,   snap_wd_d;
   logic [7:0]  snap_pc_q,   snap_pc_d;
   logic [6:0]  vga_q,       vga_d;

   logic        pix_tick;
   logic        visible;
   logic        hs;
   logic        vs;
   logic [3:0]  bit_idx;
   logic [15:0] pc_word;
   logic [4:0]  colour;

   assign pix_tick = (div_q == 2'd3);
   assign visible  = (h_q < 10'd640) && (v_q < 10'd480);
   assign hs       = !((h_q >= 10'd656) && (h_q <= 10'd751));
   assign vs       = !((v_q >= 10'd490) && (v_q <= 10'd491));
   assign bit_idx  = 4'd15 - c_q;
   assign pc_word  = {8'h00, snap_pc_q};

   // Cell 0 carries the MSB; offset 39 of every cell is the black gap column.
   always_comb begin
      colour = '0;
      if (visible && (o_q != 6'd39)) begin
         if (v_q < 10'd160) begin
            colour[2:1] = {2{snap_insn_q[bit_idx]}};
         end else if (v_q < 10'd320) begin
            colour[4:3] = {2{snap_wd_q[bit_idx]}};
         end else begin
            colour[0] = pc_word[bit_idx];
         end
      end
   end

   always_comb begin
      div_d       = div_q + 2'd1;
      h_d         = h_q;
      v_d         = v_q;
      c_d         = c_q;
      o_d         = o_q;
      vga_d       = vga_q;
      snap_insn_d = snap_insn_q;
      snap_wd_d   = snap_wd_q;
      snap_pc_d   = snap_pc_q;
      wd_live_d   = dbg.DBG_WE ? dbg.DBG_WD : wd_live_q;

      if (pix_tick) begin
         vga_d = {hs, vs, colour};

         if (h_q == 10'd799) begin
            h_d = '0;
            c_d = '0;
            o_d = '0;
            v_d = (v_q == 10'd524) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
            if (h_q < 10'd640) begin
               if (o_q == 6'd39) begin
                  o_d = '0;
                  c_d = c_q + 4'd1;
               end else begin
                  o_d = o_q + 6'd1;
               end
            end
         end

         // wd_live_q (not wd_live_d) so a same-cycle write lands one frame later.
         if ((h_q == 10'd0) && (v_q == 10'd480)) begin
            snap_insn_d = dbg.DBG_INSN;
            snap_wd_d   = wd_live_q;
            snap_pc_d   = dbg.DBG_PC;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         div_q       <= '0;
         h_q         <= '0;
         v_q         <= '0;
         c_q         <= '0;
         o_q         <= '0;
         wd_live_q   <= '0;
         snap_insn_q <= '0;
         snap_wd_q   <= '0;
         snap_pc_q   <= '0;
         vga_q       <= 7'h60;
      end else begin
         div_q       <= div_d;
         h_q         <= h_d;
         v_q         <= v_d;
         c_q         <= c_d;
         o_q         <= o_d;
         wd_live_q   <= wd_live_d;
         snap_insn_q <= snap_insn_d;
         snap_wd_q   <= snap_wd_d;
         snap_pc_q   <= snap_pc_d;
         vga_q       <= vga_d;
      end
   end

   assign dbg.VGA = vga_q;

endmodule

// File: tb/tb_vga_debug_display.sv
// Bench for vga_debug_display: per-cycle comparison against a coordinate-arithmetic screen model,
// plus literal pixel and sync-timing expectations.
module tb_vga_debug_display;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   vga_debug_display_if dbg ();

   vga_debug_display u_dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .dbg   (dbg.slave)
   );

   int checks = 0;
   int failures = 0;

   // Model state: edges since reset release, captured probe values, expected VGA.
   int          m_n = 0;
   logic [15:0] m_wd = '0;
   logic [15:0] m_si = '0;
   logic [15:0] m_sw = '0;
   logic [7:0]  m_sp = '0;
   logic [6:0]  m_vga = 7'h60;

   function automatic logic [6:0] expect_pix(input int h, input int v);
      logic        hs_b;
      logic        vs_b;
      logic [4:0]  col;
      logic [15:0] pcw;
      int          bidx;
      hs_b = !(h >= 656 && h <= 751);
      vs_b = !(v >= 490 && v <= 491);
      col  = '0;
      pcw  = {8'h00, m_sp};
      if (h < 640 && v < 480 && (h % 40) != 39) begin
         bidx = 15 - h / 40;
         case (v / 160)
            0: if (m_si[bidx]) col = 5'b00110;
            1: if (m_sw[bidx]) col = 5'b11000;
            default: if (pcw[bidx]) col = 5'b00001;
         endcase
      end
      return {hs_b, vs_b, col};
   endfunction

   // Edge count after which VGA shows the pixel at (frame f, line v, column h).
   function automatic int tick_edge(input int f, input int v, input int h);
      return 4 * (f * 420000 + v * 800 + h + 1);
   endfunction

   always @(posedge CLK) begin
      int t;
      int p;
      if (!RST_N) begin
         m_n = 0; m_wd = '0; m_si = '0; m_sw = '0; m_sp = '0; m_vga = 7'h60;
      end else begin
         m_n = m_n + 1;
         if (m_n % 4 == 0) begin
            t = m_n / 4;
            p = t - 1;
            if ((p % 800) == 0 && ((p / 800) % 525) == 480) begin
               m_si = dbg.DBG_INSN;
               m_sw = m_wd;
               m_sp = dbg.DBG_PC;
            end
            m_vga = expect_pix(p % 800, (p / 800) % 525);
         end
         if (dbg.DBG_WE) m_wd = dbg.DBG_WD;
      end
   end

   // Sync edge timestamps (in model edge counts) for interval checks.
   int hs_fall0 = -1, hs_fall1 = -1, hs_rise = -1;
   int vs_fall0 = -1, vs_fall1 = -1, vs_rise = -1;
   logic [6:0] prev_vga = 7'h60;

   always @(negedge CLK) begin
      if (!RST_N) begin
         checks = checks + 1;
         if (dbg.VGA !== 7'h60) begin
            failures = failures + 1;
            $display("FAIL reset_hold: VGA=%h required=60", dbg.VGA);
         end
         hs_fall0 = -1; hs_fall1 = -1; hs_rise = -1;
         vs_fall0 = -1; vs_fall1 = -1; vs_rise = -1;
         prev_vga = 7'h60;
      end else begin
         checks = checks + 1;
         if (dbg.VGA !== m_vga) begin
            failures = failures + 1;
            $display("FAIL model n=%0d: VGA=%h required=%h", m_n, dbg.VGA, m_vga);
         end
         if (!dbg.VGA[6] || !dbg.VGA[5]) begin
            checks = checks + 1;
            if (dbg.VGA[4:0] !== 5'b0) begin
               failures = failures + 1;
               $display("FAIL blank_in_sync n=%0d: colour=%b required=00000", m_n, dbg.VGA[4:0]);
            end
         end
         if (prev_vga[6] && !dbg.VGA[6]) begin
            if (hs_fall0 < 0) hs_fall0 = m_n;
            else if (hs_fall1 < 0) hs_fall1 = m_n;
         end
         if (!prev_vga[6] && dbg.VGA[6] && hs_fall0 >= 0 && hs_rise < 0) hs_rise = m_n;
         if (prev_vga[5] && !dbg.VGA[5]) begin
            if (vs_fall0 < 0) vs_fall0 = m_n;
            else if (vs_fall1 < 0) vs_fall1 = m_n;
         end
         if (!prev_vga[5] && dbg.VGA[5] && vs_fall0 >= 0 && vs_rise < 0) vs_rise = m_n;
         prev_vga = dbg.VGA;
      end
   end

   typedef struct {
      int         f;
      int         v;
      int         h;
      logic [6:0] exp;
   } pix_chk_t;

   pix_chk_t pix_list[14];

   task automatic check_val(input string name, input int act, input int req);
      checks = checks + 1;
      if (act != req) begin
         failures = failures + 1;
         $display("FAIL %s: got=%0d required=%0d", name, act, req);
      end
   endtask

   initial begin
      logic [15:0] newinsn;
      int          s0, s1, ch, fin, e, idx;

      newinsn = 16'($urandom) & 16'h7FFE | 16'h0001;
      // Pixels after the first snapshot: INSN=8001, WD=A5A5, PC=03; then newinsn and A5A5 again; then 1234.
      pix_list[0]  = '{0,  10,   0, 7'h60};
      pix_list[1]  = '{1,  10,   0, 7'h66};
      pix_list[2]  = '{1,  10,  39, 7'h60};
      pix_list[3]  = '{1,  10,  40, 7'h60};
      pix_list[4]  = '{1,  10, 605, 7'h66};
      pix_list[5]  = '{1, 170,   0, 7'h78};
      pix_list[6]  = '{1, 170,  40, 7'h60};
      pix_list[7]  = '{1, 170,  80, 7'h78};
      pix_list[8]  = '{1, 330, 520, 7'h60};
      pix_list[9]  = '{1, 330, 560, 7'h61};
      pix_list[10] = '{1, 330, 600, 7'h61};
      pix_list[11] = '{2,  10, 600, 7'h66};
      pix_list[12] = '{2, 170,   0, 7'h78};
      pix_list[13] = '{3, 170, 120, 7'h78};

      dbg.DBG_PC = '0; dbg.DBG_INSN = '0; dbg.DBG_WD = '0; dbg.DBG_WE = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;

      // Run into the HS pulse (h=700), then assert reset between clock edges.
      while (m_n < tick_edge(0, 0, 700)) @(negedge CLK);
      #1 RST_N = 1'b0;
      #1;
      checks = checks + 1;
      if (dbg.VGA !== 7'h60) begin
         failures = failures + 1;
         $display("FAIL async_reset: VGA=%h required=60", dbg.VGA);
      end
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;

      s0  = tick_edge(0, 480, 0);
      s1  = tick_edge(1, 480, 0);
      ch  = tick_edge(1, 200, 0);
      fin = tick_edge(3, 200, 0) + 4;
      idx = 0;
      while (m_n < fin) begin
         @(negedge CLK);
         if (idx < 14 && m_n == tick_edge(pix_list[idx].f, pix_list[idx].v, pix_list[idx].h)) begin
            checks = checks + 1;
            if (dbg.VGA !== pix_list[idx].exp) begin
               failures = failures + 1;
               $display("FAIL pixel f%0d v%0d h%0d: VGA=%h required=%h",
                        pix_list[idx].f, pix_list[idx].v, pix_list[idx].h, dbg.VGA, pix_list[idx].exp);
            end
            idx = idx + 1;
         end
         e = m_n + 1;
         if (e < s0 - 100) begin
            dbg.DBG_PC   = 8'($urandom);
            dbg.DBG_INSN = 16'($urandom);
            dbg.DBG_WD   = 16'($urandom);
            dbg.DBG_WE   = ($urandom_range(0, 15) == 0);
         end else if (e < s1) begin
            dbg.DBG_PC   = 8'h03;
            dbg.DBG_INSN = (e >= ch) ? newinsn : 16'h8001;
            dbg.DBG_WE   = (e == s0 - 50);
            if (e == s0 - 50) dbg.DBG_WD = 16'hA5A5;
            else if (e > s0 - 50 && e < s0) dbg.DBG_WD = 16'hFFFF;
            else dbg.DBG_WD = 16'($urandom);
         end else begin
            dbg.DBG_PC   = 8'h03;
            dbg.DBG_INSN = newinsn;
            dbg.DBG_WE   = (e == s1);
            dbg.DBG_WD   = (e == s1) ? 16'h1234 : 16'($urandom);
         end
      end

      check_val("pixel_list_done", idx, 14);
      check_val("hs_first_fall", hs_fall0, 2628);
      check_val("hs_low", hs_rise - hs_fall0, 384);
      check_val("hs_period", hs_fall1 - hs_fall0, 3200);
      check_val("vs_first_fall", vs_fall0, 1568004);
      check_val("vs_low", vs_rise - vs_fall0, 6400);
      check_val("vs_period", vs_fall1 - vs_fall0, 1680000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
